mem_lsu: RTL and testbench

//  Parametrised load/store MEM stage for GeMIPS; sits between EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_lsu_pkg.sv | 47 ++++
 rtl/mem_lane_align.sv | 86 ++++++++
 rtl/mem_lsu.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types for the GeMIPS MEM stage: memory op codes, exception codes,
// FSM states and lane-geometry helpers.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_LWU  = 4'd6,
    OP_LD   = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SD   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_LMIS = 2'd1,
    EXC_SMIS = 2'd2,
    EXC_BUS  = 2'd3
  } exc_code_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } acc_size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } lsu_state_e;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store replication, misalignment
// detection and load extraction with sign/zero extension.
module mem_lane_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]                 op,
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic [DATA_W-1:0]          sdata,
  input  logic [DATA_W-1:0]          rdata,
  output logic [DATA_W/8-1:0]        be,
  output logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          ldata,
  output logic                       misalign,
  output logic                       is_load,
  output logic                       is_store
);

  localparam int   NL   = DATA_W / 8;
  localparam logic WIDE = (DATA_W == 64);

  acc_size_e         size_s;
  logic              sgn_s;
  logic [DATA_W-1:0] sh_s;

  // Decode op into access size, direction and signedness; 64-bit ops vanish on a 32-bit datapath
  always_comb begin
    size_s   = SZ_B;
    sgn_s    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (mem_op_e'(op))
      OP_LB:   begin is_load = 1'b1; sgn_s = 1'b1; size_s = SZ_B; end
      OP_LBU:  begin is_load = 1'b1; size_s = SZ_B; end
      OP_LH:   begin is_load = 1'b1; sgn_s = 1'b1; size_s = SZ_H; end
      OP_LHU:  begin is_load = 1'b1; size_s = SZ_H; end
      OP_LW:   begin is_load = 1'b1; sgn_s = 1'b1; size_s = SZ_W; end
      OP_LWU:  begin is_load = WIDE; size_s = SZ_W; end
      OP_LD:   begin is_load = WIDE; size_s = SZ_D; end
      OP_SB:   begin is_store = 1'b1; size_s = SZ_B; end
      OP_SH:   begin is_store = 1'b1; size_s = SZ_H; end
      OP_SW:   begin is_store = 1'b1; size_s = SZ_W; end
      OP_SD:   begin is_store = WIDE; size_s = SZ_D; end
      default: begin is_load = 1'b0; is_store = 1'b0; end
    endcase
  end

  // Lane placement for stores and lane extraction for loads
  always_comb begin
    sh_s     = rdata >> {off, 3'b000};
    be       = {NL{1'b0}};
    wdata    = {DATA_W{1'b0}};
    ldata    = {DATA_W{1'b0}};
    misalign = 1'b0;
    case (size_s)
      SZ_B: begin
        be    = NL'(1'b1) << off;
        wdata = {NL{sdata[7:0]}};
        ldata = sgn_s ? DATA_W'($signed(sh_s[7:0])) : DATA_W'(sh_s[7:0]);
      end
      SZ_H: begin
        be       = NL'(2'b11) << off;
        wdata    = {(NL/2){sdata[15:0]}};
        ldata    = sgn_s ? DATA_W'($signed(sh_s[15:0])) : DATA_W'(sh_s[15:0]);
        misalign = off[0];
      end
      SZ_W: begin
        be       = NL'(4'hF) << off;
        wdata    = {(NL/4){sdata[31:0]}};
        ldata    = sgn_s ? DATA_W'($signed(sh_s[31:0])) : DATA_W'(sh_s[31:0]);
        misalign = |off[1:0];
      end
      SZ_D: begin
        be       = {NL{1'b1}};
        wdata    = sdata;
        ldata    = rdata;
        misalign = |off;
      end
      default: begin
        be = {NL{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// GeMIPS MEM stage: drives the req/ack data-RAM port, stalls the pipeline
// while an access is outstanding, and registers WB results and exceptions.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic                we_i,
  input  logic [REG_AW-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [3:0]          mem_op_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  output logic                stall_o,
  output logic                we_o,
  output logic [REG_AW-1:0]   waddr_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic                exc_o,
  output logic [1:0]          exc_code_o,
  output logic [ADDR_W-1:0]   bad_addr_o,
  output logic                ram_req_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W/8-1:0] ram_be_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic [DATA_W-1:0]   ram_rdata_i,
  input  logic                ram_ack_i
);

  localparam int NL    = lanes(DATA_W);
  localparam int OFF_W = off_width(DATA_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic             TMO_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

  lsu_state_e        state_r, state_n;
  logic [3:0]        op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [NL-1:0]     be_r;
  logic [DATA_W-1:0] st_data_r;
  logic              is_st_r, we_cap_r, kill_r;
  logic [REG_AW-1:0] waddr_cap_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              we_r, exc_r;
  logic [REG_AW-1:0] waddr_r;
  logic [DATA_W-1:0] wdata_r;
  exc_code_e         exc_code_r;
  logic [ADDR_W-1:0] bad_addr_r;

  logic              we_s, exc_s, stall_s, cap_s, kill_s, tmo_s, req_s;
  logic [REG_AW-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;
  exc_code_e         exc_code_s;
  logic [ADDR_W-1:0] bad_addr_s;

  logic [3:0]        al_op_s;
  logic [OFF_W-1:0]  al_off_s;
  logic [NL-1:0]     al_be_s;
  logic [DATA_W-1:0] al_wdata_s, al_ldata_s;
  logic              al_mis_s, al_ld_s, al_st_s;

  // The aligner sees the incoming op in IDLE and the captured op while the access is outstanding
  assign al_op_s  = (state_r == ST_ACCESS) ? op_r : mem_op_i;
  assign al_off_s = (state_r == ST_ACCESS) ? addr_r[OFF_W-1:0] : mem_addr_i[OFF_W-1:0];

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .op       (al_op_s),
    .off      (al_off_s),
    .sdata    (mem_data_i),
    .rdata    (ram_rdata_i),
    .be       (al_be_s),
    .wdata    (al_wdata_s),
    .ldata    (al_ldata_s),
    .misalign (al_mis_s),
    .is_load  (al_ld_s),
    .is_store (al_st_s)
  );

  assign req_s  = (state_r == ST_ACCESS);
  assign kill_s = kill_r | flush_i;
  assign tmo_s  = TMO_EN && (cnt_r == TMO_CNT);

  // Next-state, stall and next WB/exception values
  always_comb begin
    state_n    = state_r;
    stall_s    = 1'b0;
    cap_s      = 1'b0;
    we_s       = 1'b0;
    waddr_s    = waddr_r;
    wdata_s    = wdata_r;
    exc_s      = 1'b0;
    exc_code_s = EXC_NONE;
    bad_addr_s = {ADDR_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          if (al_ld_s || al_st_s) begin
            if (al_mis_s) begin
              exc_s      = 1'b1;
              exc_code_s = al_ld_s ? EXC_LMIS : EXC_SMIS;
              bad_addr_s = mem_addr_i;
            end else begin
              stall_s = 1'b1;
              cap_s   = 1'b1;
              state_n = ST_ACCESS;
            end
          end else begin
            we_s    = we_i;
            waddr_s = waddr_i;
            wdata_s = wdata_i;
          end
        end else begin
          we_s = 1'b0;
        end
      end
      ST_ACCESS: begin
        // An ack in the expiry cycle takes priority over the timeout
        if (ram_ack_i) begin
          state_n = ST_IDLE;
          if (!kill_s && !is_st_r) begin
            we_s    = we_cap_r;
            waddr_s = waddr_cap_r;
            wdata_s = al_ldata_s;
          end else begin
            we_s = 1'b0;
          end
        end else if (tmo_s) begin
          state_n = ST_IDLE;
          if (!kill_s) begin
            exc_s      = 1'b1;
            exc_code_s = EXC_BUS;
            bad_addr_s = addr_r;
          end else begin
            exc_s = 1'b0;
          end
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= state_n;
  end

  // Capture the accepted memory op; held stable for the whole access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r        <= 4'd0;
      addr_r      <= {ADDR_W{1'b0}};
      be_r        <= {NL{1'b0}};
      st_data_r   <= {DATA_W{1'b0}};
      is_st_r     <= 1'b0;
      we_cap_r    <= 1'b0;
      waddr_cap_r <= {REG_AW{1'b0}};
    end else if (cap_s) begin
      op_r        <= mem_op_i;
      addr_r      <= mem_addr_i;
      be_r        <= al_be_s;
      st_data_r   <= al_wdata_s;
      is_st_r     <= al_st_s;
      we_cap_r    <= we_i;
      waddr_cap_r <= waddr_i;
    end
  end

  // Wait counter and kill flag, both cleared on entry to ACCESS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      kill_r <= 1'b0;
    end else if (cap_s) begin
      cnt_r  <= {CNT_W{1'b0}};
      kill_r <= 1'b0;
    end else if (state_r == ST_ACCESS) begin
      cnt_r  <= cnt_r + CNT_W'(1);
      kill_r <= kill_r | flush_i;
    end
  end

  // WB and exception output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r       <= 1'b0;
      waddr_r    <= {REG_AW{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      exc_r      <= 1'b0;
      exc_code_r <= EXC_NONE;
      bad_addr_r <= {ADDR_W{1'b0}};
    end else begin
      we_r       <= we_s;
      waddr_r    <= waddr_s;
      wdata_r    <= wdata_s;
      exc_r      <= exc_s;
      exc_code_r <= exc_code_s;
      bad_addr_r <= bad_addr_s;
    end
  end

  assign stall_o     = stall_s & rst;
  assign we_o        = we_r;
  assign waddr_o     = waddr_r;
  assign wdata_o     = wdata_r;
  assign exc_o       = exc_r;
  assign exc_code_o  = exc_code_r;
  assign bad_addr_o  = bad_addr_r;
  assign ram_req_o   = req_s;
  assign ram_we_o    = req_s & is_st_r;
  assign ram_addr_o  = req_s ? {addr_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : {ADDR_W{1'b0}};
  assign ram_be_o    = req_s ? be_r : {NL{1'b0}};
  assign ram_wdata_o = (req_s && is_st_r) ? st_data_r : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: expected WB/exception results are queued at
// issue and compared when the DUT raises we_o or exc_o.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk, rst, valid_i, flush_i, we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i, mem_addr_i, mem_data_i, ram_rdata_i;
  logic [3:0]  mem_op_i;
  logic        ram_ack_i;
  logic        stall_o, we_o, exc_o, ram_req_o, ram_we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o, bad_addr_o, ram_addr_o, ram_wdata_o;
  logic [1:0]  exc_code_o;
  logic [3:0]  ram_be_o;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        exc;
    logic [1:0]  code;
    logic [31:0] bad;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_AW(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .we_i(we_i),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .stall_o(stall_o), .we_o(we_o), .waddr_o(waddr_o),
    .wdata_o(wdata_o), .exc_o(exc_o), .exc_code_o(exc_code_o), .bad_addr_o(bad_addr_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic exc, input logic [1:0] code, input logic [31:0] bad);
    mk = '{we, wa, wd, exc, code, bad};
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst && (we_o || exc_o)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", {62'd0, we_o, exc_o}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("wb_we", we_o, e.we);
        if (e.we) begin
          check("wb_waddr", waddr_o, e.waddr);
          check("wb_wdata", wdata_o, e.wdata);
        end
        check("wb_exc", exc_o, e.exc);
        if (e.exc) begin
          check("wb_code", exc_code_o, e.code);
          check("wb_bad", bad_addr_o, e.bad);
        end
      end
    end
  end

  // Issue one memory op and serve the RAM port; waits<0 never acks
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input int waits, input logic [31:0] rd, input int flush_cyc,
                         output int sc, output int rc, output logic [3:0] be0,
                         output logic [31:0] wd0, output logic we0, output logic [31:0] ad0,
                         output logic stab);
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_data_i = sd;
    we_i = 1'b1; waddr_i = 5'd7;
    #1 sc = int'(stall_o);
    rc = 0; stab = 1'b1; be0 = 4'd0; wd0 = 32'd0; we0 = 1'b0; ad0 = 32'd0;
    @(negedge clk);
    valid_i = 1'b0; mem_op_i = OP_NONE; we_i = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (!ram_req_o) break;
      if (c == 0) begin
        be0 = ram_be_o; wd0 = ram_wdata_o; we0 = ram_we_o; ad0 = ram_addr_o;
      end else if (ram_addr_o !== ad0 || ram_be_o !== be0) begin
        stab = 1'b0;
      end
      rc++;
      flush_i = (c == flush_cyc);
      if (c == waits) begin
        ram_ack_i = 1'b1; ram_rdata_i = rd;
      end
      #1 if (stall_o) sc++;
      @(negedge clk);
      ram_ack_i = 1'b0; flush_i = 1'b0; ram_rdata_i = 32'd0;
    end
  endtask

  task automatic do_alu(input logic [3:0] op, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = op; we_i = we; waddr_i = wa; wdata_i = wd; mem_addr_i = 32'h44;
    if (we) sb.push_back(mk(1'b1, wa, wd, 1'b0, 2'd0, 32'd0));
    #1 check("alu_stall", stall_o, 1'b0);
    @(negedge clk);
    valid_i = 1'b0; we_i = 1'b0; mem_op_i = OP_NONE;
    check("alu_latency", we_o, we);
    check("alu_noreq", ram_req_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sc, rc;
    logic [3:0] be;
    logic [31:0] wd, ra;
    logic rwe, stab;
    rst = 1'b0; valid_i = 1'b0; flush_i = 1'b0; we_i = 1'b0; waddr_i = 5'd0;
    wdata_i = 32'd0; mem_op_i = OP_NONE; mem_addr_i = 32'd0; mem_data_i = 32'd0;
    ram_rdata_i = 32'd0; ram_ack_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", ram_req_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_we", we_o, 1'b0);
    check("rst_exc", exc_o, 1'b0);
    check("rst_wdata", wdata_o, 32'd0);
    rst = 1'b1;

    // Signed byte load, ack one cycle after the request
    sb.push_back(mk(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 2'd0, 32'd0));
    run_mem(OP_LB, 32'h1003, 32'd0, 1, 32'h80FF_0000, -1, sc, rc, be, wd, rwe, ra, stab);
    check("lb_be", be, 4'b1000);
    check("lb_stall_cycles", sc, 2);
    check("lb_ram_we", rwe, 1'b0);
    check("lb_ram_addr", ra, 32'h1000);

    // Halfword store with lane replication
    run_mem(OP_SH, 32'h2002, 32'h0000_1234, 0, 32'd0, -1, sc, rc, be, wd, rwe, ra, stab);
    check("sh_be", be, 4'b1100);
    check("sh_wdata", wd, 32'h1234_1234);
    check("sh_ram_we", rwe, 1'b1);
    check("sh_ram_addr", ra, 32'h2000);
    check("sh_we_o", we_o, 1'b0);

    // Misaligned word load
    sb.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 2'd1, 32'h3001));
    run_mem(OP_LW, 32'h3001, 32'd0, 0, 32'd0, -1, sc, rc, be, wd, rwe, ra, stab);
    check("lwmis_req_cycles", rc, 0);
    check("lwmis_stall", sc, 0);
    check("lwmis_exc", exc_o, 1'b1);
    @(negedge clk);
    check("lwmis_exc_pulse", exc_o, 1'b0);

    // Unsigned byte load with three wait cycles
    sb.push_back(mk(1'b1, 5'd7, 32'h0000_00F0, 1'b0, 2'd0, 32'd0));
    run_mem(OP_LBU, 32'h10, 32'd0, 3, 32'h0000_00F0, -1, sc, rc, be, wd, rwe, ra, stab);
    check("lbu_stall_cycles", sc, 4);
    check("lbu_addr_stable", stab, 1'b1);
    check("lbu_ram_addr", ra, 32'h10);
    check("lbu_be", be, 4'b0001);

    // Halfword loads, signed and unsigned, from the upper half
    sb.push_back(mk(1'b1, 5'd7, 32'hFFFF_8001, 1'b0, 2'd0, 32'd0));
    run_mem(OP_LH, 32'h6, 32'd0, 0, 32'h8001_0000, -1, sc, rc, be, wd, rwe, ra, stab);
    check("lh_be", be, 4'b1100);
    sb.push_back(mk(1'b1, 5'd7, 32'h0000_8001, 1'b0, 2'd0, 32'd0));
    run_mem(OP_LHU, 32'h6, 32'd0, 0, 32'h8001_0000, -1, sc, rc, be, wd, rwe, ra, stab);
    check("lhu_stall_cycles", sc, 1);

    // Byte store and misaligned word store
    run_mem(OP_SB, 32'h5, 32'h0000_00AB, 0, 32'd0, -1, sc, rc, be, wd, rwe, ra, stab);
    check("sb_be", be, 4'b0010);
    check("sb_wdata", wd, 32'hABAB_ABAB);
    sb.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 2'd2, 32'hA));
    run_mem(OP_SW, 32'hA, 32'h1111_2222, 0, 32'd0, -1, sc, rc, be, wd, rwe, ra, stab);
    check("swmis_req_cycles", rc, 0);

    // Bus timeout, then an ALU op
    sb.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 2'd3, 32'h40));
    run_mem(OP_LW, 32'h40, 32'd0, -1, 32'd0, -1, sc, rc, be, wd, rwe, ra, stab);
    check("tmo_stall_cycles", sc, 5);
    check("tmo_req_dropped", ram_req_o, 1'b0);
    check("tmo_exc", exc_o, 1'b1);
    do_alu(OP_NONE, 1'b1, 5'd3, 32'hDEAD_BEEF);
    // LWU on a 32-bit datapath behaves like a non-memory op
    do_alu(OP_LWU, 1'b1, 5'd9, 32'h0000_55AA);

    // Flush during an access: it completes but writes nothing back
    run_mem(OP_LW, 32'h50, 32'd0, 2, 32'h1234_5678, 0, sc, rc, be, wd, rwe, ra, stab);
    check("flush_req_cycles", rc, 3);
    check("flush_we_o", we_o, 1'b0);

    // Reset mid-access
    @(negedge clk);
    valid_i = 1'b1; mem_op_i = OP_LW; mem_addr_i = 32'h60; we_i = 1'b1; waddr_i = 5'd4;
    @(negedge clk);
    valid_i = 1'b0; mem_op_i = OP_NONE; we_i = 1'b0;
    check("rst_mid_req_before", ram_req_o, 1'b1);
    rst = 1'b0;
    #1 check("rst_mid_req_async", ram_req_o, 1'b0);
    check("rst_mid_stall", stall_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(mk(1'b1, 5'd7, 32'h0000_00AB, 1'b0, 2'd0, 32'd0));
    run_mem(OP_LBU, 32'h61, 32'd0, 0, 32'h0000_AB00, -1, sc, rc, be, wd, rwe, ra, stab);
    check("post_rst_stall", sc, 1);
    check("post_rst_addr", ra, 32'h60);

    repeat (2) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
